// File: rtl/cpu_pkg.sv
// Shared Project3 CPU definitions: datapath and instruction-memory geometry,
// fetch state encoding and the primary/secondary opcode fields used by decode and execute.
package cpu_pkg;

    localparam int          DBITS        = 32;
    localparam logic [31:0] INSTSIZE     = 32'd4;
    localparam logic [31:0] STARTPC      = 32'h40;
    localparam int          IMEMADDRBITS = 13;
    localparam int          IMEMWORDBITS = 2;
    localparam int          IMEMWORDS    = 2048;
    localparam string       IMEMINITFILE = "Sorter2.mif";

    typedef enum logic {
        WAIT_LOCK = 1'b0,
        RUN       = 1'b1
    } fetch_state_t;

    // Primary opcode field, instruction bits [31:28]
    localparam logic [3:0] OP1_ALUR  = 4'b0000;
    localparam logic [3:0] OP1_ALUI  = 4'b1000;
    localparam logic [3:0] OP1_CMPR  = 4'b0010;
    localparam logic [3:0] OP1_CMPI  = 4'b1010;
    localparam logic [3:0] OP1_BCOND = 4'b0110;
    localparam logic [3:0] OP1_SW    = 4'b0101;
    localparam logic [3:0] OP1_LW    = 4'b1001;
    localparam logic [3:0] OP1_JAL   = 4'b1011;

    // Secondary opcode field for ALU operations
    localparam logic [3:0] OP2_ADD  = 4'b0000;
    localparam logic [3:0] OP2_SUB  = 4'b0001;
    localparam logic [3:0] OP2_AND  = 4'b0100;
    localparam logic [3:0] OP2_OR   = 4'b0101;
    localparam logic [3:0] OP2_XOR  = 4'b0110;
    localparam logic [3:0] OP2_NAND = 4'b1100;
    localparam logic [3:0] OP2_NOR  = 4'b1101;
    localparam logic [3:0] OP2_XNOR = 4'b1110;

endpackage

// File: rtl/imem_rom.sv
// Synchronous-read instruction ROM; contents come from the init file at
// configuration time, the data output is registered and there is no write port.
module imem_rom
    import cpu_pkg::*;
#(
    parameter int    WIDTH    = DBITS,
    parameter int    ADDRBITS = IMEMADDRBITS - IMEMWORDBITS,
    parameter int    WORDS    = IMEMWORDS,
    parameter string INITFILE = IMEMINITFILE
) (
    input  logic                clk,
    input  logic [ADDRBITS-1:0] addr,
    output logic [WIDTH-1:0]    data
);

    (* ram_init_file = INITFILE *)
    logic [WIDTH-1:0] mem [WORDS] = '{default: '0};

    // No reset on the read register so the ROM maps onto block RAM.
    always_ff @(posedge clk) begin
        data <= mem[addr];
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads the instruction ROM and
// presents a registered instruction/PC pair to decode, honouring stalls, redirects and PLL lock.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int               DBITS        = cpu_pkg::DBITS,
    parameter logic [DBITS-1:0] INSTSIZE     = cpu_pkg::INSTSIZE,
    parameter logic [DBITS-1:0] STARTPC      = cpu_pkg::STARTPC,
    parameter int               IMEMADDRBITS = cpu_pkg::IMEMADDRBITS,
    parameter int               IMEMWORDBITS = cpu_pkg::IMEMWORDBITS,
    parameter int               IMEMWORDS    = cpu_pkg::IMEMWORDS,
    parameter string            IMEMINITFILE = cpu_pkg::IMEMINITFILE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lock,
    input  logic             stall_D,
    input  logic             redirect_B,
    input  logic [DBITS-1:0] redirtarg_B,
    output logic [DBITS-1:0] inst_D,
    output logic [DBITS-1:0] pc_D,
    output logic [DBITS-1:0] pcplus_D,
    output logic             valid_D,
    output logic [31:0]      fetchcnt,
    output logic [31:0]      stallcnt
);

    localparam logic [DBITS-1:0] ALIGN_MASK = ~DBITS'(3);

    fetch_state_t     state;
    fetch_state_t     state_next;
    logic [DBITS-1:0] pcnext;
    logic [DBITS-1:0] rom_data;
    logic             load;
    logic             started;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= WAIT_LOCK;
        end else begin
            state <= state_next;
        end
    end

    // A lock=0 edge in RUN holds the PC like WAIT_LOCK does, so the word at
    // pc_D was not consumed and is re-presented once lock returns.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        pcnext     = pc_D;
        case (state)
            WAIT_LOCK: begin
                pcnext = started ? pc_D : STARTPC;
                if (lock) begin
                    state_next = RUN;
                    load       = 1'b1;
                end
            end
            RUN: begin
                if (!lock) begin
                    state_next = WAIT_LOCK;
                end else begin
                    load = 1'b1;
                    if (redirect_B) begin
                        pcnext = redirtarg_B & ALIGN_MASK;
                    end else if (stall_D) begin
                        pcnext = pc_D;
                    end else begin
                        pcnext = pcplus_D;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_D    <= STARTPC;
            valid_D <= 1'b0;
            started <= 1'b0;
        end else if (load) begin
            pc_D    <= pcnext;
            valid_D <= 1'b1;
            started <= 1'b1;
        end else begin
            valid_D <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetchcnt <= 32'd0;
            stallcnt <= 32'd0;
        end else begin
            if (valid_D && !stall_D && lock) begin
                fetchcnt <= fetchcnt + 32'd1;
            end
            if (valid_D && stall_D) begin
                stallcnt <= stallcnt + 32'd1;
            end
        end
    end

    // The ROM is addressed with pcnext so its registered output lines up with pc_D.
    imem_rom #(
        .WIDTH    (DBITS),
        .ADDRBITS (IMEMADDRBITS - IMEMWORDBITS),
        .WORDS    (IMEMWORDS),
        .INITFILE (IMEMINITFILE)
    ) u_rom (
        .clk  (clk),
        .addr (pcnext[IMEMADDRBITS-1:IMEMWORDBITS]),
        .data (rom_data)
    );

    assign pcplus_D = pc_D + INSTSIZE;
    assign inst_D   = valid_D ? rom_data : '0;

endmodule
